// File: rtl/prog_rst_pkg.sv
// Shared types and output reset values for the programming-reset controller.
package prog_rst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PROG     = 2'd2,
    RELEASE  = 2'd3
  } prog_fsm_e;

  localparam logic PROG_RST_RST = 1'b1;
  localparam logic LD_EN_RST    = 1'b0;
  localparam logic BUSY_RST     = 1'b0;
  localparam logic TIMEOUT_RST  = 1'b0;

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module rst_sync_2ff #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RstVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/prog_rst_ctrl.sv
// Debounces the programming request pin and holds prog_rst_no low while the loader runs.
// Optional forced release after TimeoutCnt PROG cycles when PROG_TIMEOUT_EN is defined.
module prog_rst_ctrl
  import prog_rst_pkg::*;
#(
  parameter int unsigned DebounceCnt = 1000,
  parameter int unsigned HoldMin     = 16
`ifdef PROG_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCnt  = 1048576
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic prog_btn_ni,
  input  logic ld_done_i,
  input  logic ld_err_i,
  output logic prog_rst_no,
  output logic ld_en_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned DebW = $clog2(DebounceCnt);
  localparam int unsigned HoldW = (HoldMin > 1) ? $clog2(HoldMin) : 1;
  localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCnt - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldMin - 1);

  logic btn_s;

  prog_fsm_e        state_q, state_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             done_q, done_d;
  logic             err_blank;
  logic             done_seen;
  logic             prog_rst_q, prog_rst_d;
  logic             ld_en_q, ld_en_d;
  logic             busy_q, busy_d;

`ifdef PROG_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCnt);
  localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCnt - 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  rst_sync_2ff #(
    .RstVal(1'b1)
  ) u_btn_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (prog_btn_ni),
    .q_o   (btn_s)
  );

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = done_q;
    err_blank  = 1'b0;
    done_seen  = done_q | ld_done_i;
`ifdef PROG_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d   = DEBOUNCE;
          deb_cnt_d = '0;
        end
      end
      DEBOUNCE: begin
        if (btn_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = PROG;
          hold_cnt_d = '0;
          done_d     = 1'b0;
`ifdef PROG_TIMEOUT_EN
          to_cnt_d   = '0;
          timeout_d  = 1'b0;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      PROG: begin
        if (hold_cnt_q != HoldLast) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
`ifdef PROG_TIMEOUT_EN
        if (to_cnt_q != ToLast) begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
        // An error restarts the load: drop any remembered done and blank the enable
        if (ld_err_i) begin
          done_d    = 1'b0;
          err_blank = 1'b1;
        end else begin
          done_d = done_seen;
          if (done_seen && (hold_cnt_q == HoldLast)) begin
            state_d = RELEASE;
          end
`ifdef PROG_TIMEOUT_EN
          else if (to_cnt_q == ToLast) begin
            state_d   = RELEASE;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      RELEASE: begin
        if (btn_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    prog_rst_d = (state_d != PROG);
    ld_en_d    = (state_d == PROG) && !err_blank;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
      prog_rst_q <= PROG_RST_RST;
      ld_en_q    <= LD_EN_RST;
      busy_q     <= BUSY_RST;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      prog_rst_q <= prog_rst_d;
      ld_en_q    <= ld_en_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PROG_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q  <= '0;
      timeout_q <= TIMEOUT_RST;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = TIMEOUT_RST;
`endif

  assign prog_rst_no = prog_rst_q;
  assign ld_en_o     = ld_en_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_prog_rst_ctrl.sv
// Directed bench for prog_rst_ctrl (DebounceCnt=8, HoldMin=4, TimeoutCnt=64 with PROG_TIMEOUT_EN).
module tb_prog_rst_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_n;
  logic ld_done;
  logic ld_err;
  logic prog_rst_n;
  logic ld_en;
  logic busy;
  logic timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_rst_ctrl #(
    .DebounceCnt(8),
    .HoldMin    (4)
`ifdef PROG_TIMEOUT_EN
    ,
    .TimeoutCnt (64)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .prog_btn_ni(btn_n),
    .ld_done_i  (ld_done),
    .ld_err_i   (ld_err),
    .prog_rst_no(prog_rst_n),
    .ld_en_o    (ld_en),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  typedef struct {
    logic btn;
    logic done;
    logic err;
    logic exp_rst;
    logic exp_en;
    logic exp_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_rst"}, prog_rst_n, 1'b1);
    chk({name, "_en"}, ld_en, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  // Press the button and return the number of cycles until prog_rst_no falls
  task automatic press_and_wait(output int n);
    btn_n = 1'b0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (prog_rst_n == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic release_btn(input string name);
    btn_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle(name);
  endtask

  initial begin
    int n;
    int low;

    // busy pulses for a 5-cycle glitch, prog_rst_no never moves
    for (int i = 0; i < 11; i++) begin
      vecs[i].btn      = (i >= 2 && i <= 6) ? 1'b0 : 1'b1;
      vecs[i].done     = 1'b0;
      vecs[i].err      = 1'b0;
      vecs[i].exp_rst  = 1'b1;
      vecs[i].exp_en   = 1'b0;
      vecs[i].exp_busy = (i >= 4 && i <= 8) ? 1'b1 : 1'b0;
    end

    rst_n   = 1'b0;
    btn_n   = 1'b1;
    ld_done = 1'b0;
    ld_err  = 1'b0;

    // Test 1: reset and idle with button high
    repeat (3) begin
      @(negedge clk);
      chk_idle("in_reset");
      chk("in_reset_to", timeout, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("post_reset");
      chk("post_reset_to", timeout, 1'b0);
    end

    // Test 2: table-driven glitch rejection
    for (int i = 0; i < 11; i++) begin
      btn_n   = vecs[i].btn;
      ld_done = vecs[i].done;
      ld_err  = vecs[i].err;
      @(negedge clk);
      chk($sformatf("vec%0d_rst", i), prog_rst_n, vecs[i].exp_rst);
      chk($sformatf("vec%0d_en", i), ld_en, vecs[i].exp_en);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end

    // Test 3: held request, done at PROG cycle 10
    press_and_wait(n);
    chk_int("t3_fall_latency", n, 11);
    chk("t3_en_c0", ld_en, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("t3_rst_c%0d", c), prog_rst_n, 1'b0);
      chk($sformatf("t3_en_c%0d", c), ld_en, 1'b1);
    end
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    chk("t3_rise", prog_rst_n, 1'b1);
    chk("t3_en_off", ld_en, 1'b0);
    chk("t3_busy_rel", busy, 1'b1);
    repeat (5) @(negedge clk);
    chk("t3_busy_held", busy, 1'b1);
    chk("t3_no_retrigger", prog_rst_n, 1'b1);
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_busy_sync", busy, 1'b1);
    @(negedge clk);
    chk("t3_busy_idle", busy, 1'b0);

    // Test 4a: early done held to HoldMin boundary
    press_and_wait(n);
    chk_int("t4_fall_latency", n, 11);
    low = 1;
    for (int c = 0; c < 10; c++) begin
      ld_done = (c == 1);
      @(negedge clk);
      if (prog_rst_n == 1'b0) low++;
    end
    ld_done = 1'b0;
    chk_int("t4_low_cycles", low, 4);
    release_btn("t4_idle");

    // Test 4b: error with done at cycle 6 blanks enable for one cycle
    press_and_wait(n);
    chk_int("t4b_fall_latency", n, 11);
    repeat (6) @(negedge clk);
    ld_done = 1'b1;
    ld_err  = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    ld_err  = 1'b0;
    chk("t4b_en_blank", ld_en, 1'b0);
    chk("t4b_rst_held", prog_rst_n, 1'b0);
    chk("t4b_busy", busy, 1'b1);
    @(negedge clk);
    chk("t4b_en_back", ld_en, 1'b1);
    chk("t4b_rst_still", prog_rst_n, 1'b0);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    chk("t4b_release", prog_rst_n, 1'b1);
    release_btn("t4b_idle");

    // Test 5: no done from the loader
    press_and_wait(n);
    chk_int("t5_fall_latency", n, 11);
    low = 1;
`ifdef PROG_TIMEOUT_EN
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prog_rst_n == 1'b0) low++;
      else break;
    end
    chk_int("t5_timeout_len", low, 64);
    chk("t5_timeout_set", timeout, 1'b1);
    chk("t5_busy", busy, 1'b1);
    release_btn("t5_idle");
    chk("t5_timeout_sticky", timeout, 1'b1);
    press_and_wait(n);
    chk_int("t5_refall_latency", n, 11);
    chk("t5_timeout_clr", timeout, 1'b0);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_done_release", prog_rst_n, 1'b1);
    chk("t5_no_timeout", timeout, 1'b0);
`else
    for (int i = 0; i < 201; i++) begin
      @(negedge clk);
      if (prog_rst_n == 1'b0) low++;
    end
    chk_int("t5_low_cycles", low, 202);
    chk("t5_timeout_tied", timeout, 1'b0);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    chk("t5_done_release", prog_rst_n, 1'b1);
`endif
    release_btn("t5_end");

    // Test 6: async reset at PROG cycle 3
    press_and_wait(n);
    chk_int("t6_fall_latency", n, 11);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rst", prog_rst_n, 1'b1);
    chk("t6_async_en", ld_en, 1'b0);
    chk("t6_async_busy", busy, 1'b0);
    btn_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("t6_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
